// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester: FSM states,
// BCD widths and BCD helper functions.
package reaction_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned BCD_W       = 16;
   localparam int unsigned BCD_DIGITS  = BCD_W / BCD_DIGIT_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DELAY,
      S_ARMED,
      S_RESULT,
      S_FALSE_START,
      S_TIMEOUT
   } state_t;

   function automatic logic [BCD_W-1:0] to_bcd(input int unsigned value);
      logic [BCD_W-1:0] r;
      int unsigned      v;
      r = '0;
      v = value;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_DIGIT_W'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Most significant differing digit decides the ordering.
   function automatic logic bcd_less(input logic [BCD_W-1:0] a,
                                     input logic [BCD_W-1:0] b);
      logic lt;
      logic done;
      int unsigned idx;
      lt   = 1'b0;
      done = 1'b0;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         idx = BCD_DIGITS - 1 - i;
         if (!done && (a[idx*BCD_DIGIT_W +: BCD_DIGIT_W] != b[idx*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
            lt   = a[idx*BCD_DIGIT_W +: BCD_DIGIT_W] < b[idx*BCD_DIGIT_W +: BCD_DIGIT_W];
            done = 1'b1;
         end
      end
      return lt;
   endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, count enable and a
// flag that is high while the count equals TIMEOUT_MS.
module bcd_counter4
   import reaction_pkg::*;
#(
   parameter int unsigned TIMEOUT_MS = 9999
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [BCD_W-1:0] count,
   output logic             at_limit
);

   localparam logic [BCD_W-1:0] LIMIT_BCD = to_bcd(TIMEOUT_MS);

   logic [BCD_W-1:0] count_q, count_d;
   logic             carry;

   always_comb begin
      count_d = count_q;
      carry   = 1'b1;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
               if (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
                  count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = '0;
               end else begin
                  count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count    = count_q;
   assign at_limit = (count_q == LIMIT_BCD);

endmodule

// File: rtl/reaction_time_measure.sv
// Reaction-time tester: synchronised buttons, trial FSM and BCD ms counter.
// Define REACTION_BEST_TIME_EN to keep the best (lowest) valid time in best_bcd.
module reaction_time_measure
   import reaction_pkg::*;
#(
   parameter int unsigned TIMEOUT_MS = 9999
) (
   input  logic             clk_1ms,
   input  logic             reset,
   input  logic             go_btn,
   input  logic             react_btn,
   input  logic             delay_done,
   output logic             delay_start,
   output logic             stim_led,
   output logic [BCD_W-1:0] time_bcd,
   output logic             result_valid,
   output logic             false_start,
   output logic             timeout,
   output logic [BCD_W-1:0] best_bcd
);

   logic [1:0] go_sync_q, go_sync_d, react_sync_q, react_sync_d;
   logic       go_prev_q, go_prev_d, react_prev_q, react_prev_d;
   logic       go_rise, react_rise;

   state_t state_q, state_d;
   logic   delay_start_q, delay_start_d, stim_led_q, stim_led_d;
   logic   result_valid_q, result_valid_d, false_start_q, false_start_d;
   logic   timeout_q, timeout_d;
   logic   cnt_clr, cnt_en, at_limit, best_load;

   always_comb begin
      go_sync_d    = {go_sync_q[0], go_btn};
      react_sync_d = {react_sync_q[0], react_btn};
      go_prev_d    = go_sync_q[1];
      react_prev_d = react_sync_q[1];
   end

   assign go_rise    = go_sync_q[1] & ~go_prev_q;
   assign react_rise = react_sync_q[1] & ~react_prev_q;

   bcd_counter4 #(.TIMEOUT_MS(TIMEOUT_MS)) u_counter (
      .clk      (clk_1ms),
      .rst      (reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .count    (time_bcd),
      .at_limit (at_limit)
   );

   always_comb begin
      state_d        = state_q;
      result_valid_d = result_valid_q;
      false_start_d  = false_start_q;
      timeout_d      = timeout_q;
      cnt_clr        = 1'b0;
      cnt_en         = 1'b0;
      best_load      = 1'b0;
      case (state_q)
         S_IDLE, S_RESULT, S_FALSE_START, S_TIMEOUT: begin
            if (go_rise) begin
               state_d        = S_WAIT_DELAY;
               cnt_clr        = 1'b1;
               result_valid_d = 1'b0;
               false_start_d  = 1'b0;
               timeout_d      = 1'b0;
            end
         end
         S_WAIT_DELAY: begin
            if (react_rise) begin
               state_d       = S_FALSE_START;
               false_start_d = 1'b1;
            end else if (delay_done) begin
               state_d = S_ARMED;
               cnt_clr = 1'b1;
            end
         end
         S_ARMED: begin
            // A reaction freezes the count, even on the limit cycle.
            if (react_rise) begin
               state_d        = S_RESULT;
               result_valid_d = 1'b1;
               best_load      = 1'b1;
            end else if (at_limit) begin
               state_d   = S_TIMEOUT;
               timeout_d = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      delay_start_d = (state_d == S_WAIT_DELAY);
      stim_led_d    = (state_d == S_ARMED);
   end

   always_ff @(posedge clk_1ms or posedge reset) begin
      if (reset) begin
         go_sync_q      <= '0;
         react_sync_q   <= '0;
         go_prev_q      <= 1'b0;
         react_prev_q   <= 1'b0;
         state_q        <= S_IDLE;
         delay_start_q  <= 1'b0;
         stim_led_q     <= 1'b0;
         result_valid_q <= 1'b0;
         false_start_q  <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         go_sync_q      <= go_sync_d;
         react_sync_q   <= react_sync_d;
         go_prev_q      <= go_prev_d;
         react_prev_q   <= react_prev_d;
         state_q        <= state_d;
         delay_start_q  <= delay_start_d;
         stim_led_q     <= stim_led_d;
         result_valid_q <= result_valid_d;
         false_start_q  <= false_start_d;
         timeout_q      <= timeout_d;
      end
   end

   assign delay_start  = delay_start_q;
   assign stim_led     = stim_led_q;
   assign result_valid = result_valid_q;
   assign false_start  = false_start_q;
   assign timeout      = timeout_q;

`ifdef REACTION_BEST_TIME_EN
   logic [BCD_W-1:0] best_q, best_d;

   always_comb begin
      best_d = best_q;
      if (best_load && ((best_q == '0) || bcd_less(time_bcd, best_q))) best_d = time_bcd;
   end

   always_ff @(posedge clk_1ms or posedge reset) begin
      if (reset) best_q <= '0;
      else       best_q <= best_d;
   end

   assign best_bcd = best_q;
`else
   assign best_bcd = '0;
`endif

endmodule

// File: tb/tb_reaction_time_measure.sv
// Scoreboard bench for reaction_time_measure: a default-limit instance and a
// TIMEOUT_MS=20 instance, selected one at a time.
module tb_reaction_time_measure;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;
   logic go0 = 1'b0, react0 = 1'b0, dd0 = 1'b0;
   logic go20 = 1'b0, react20 = 1'b0, dd20 = 1'b0;
   logic ds0, led0, rv0, fs0, to0, ds20, led20, rv20, fs20, to20;
   logic [15:0] t0, b0, t20, b20;

   reaction_time_measure dut (
      .clk_1ms(clk), .reset(rst), .go_btn(go0), .react_btn(react0), .delay_done(dd0),
      .delay_start(ds0), .stim_led(led0), .time_bcd(t0), .result_valid(rv0),
      .false_start(fs0), .timeout(to0), .best_bcd(b0));

   reaction_time_measure #(.TIMEOUT_MS(20)) dut20 (
      .clk_1ms(clk), .reset(rst), .go_btn(go20), .react_btn(react20), .delay_done(dd20),
      .delay_start(ds20), .stim_led(led20), .time_bcd(t20), .result_valid(rv20),
      .false_start(fs20), .timeout(to20), .best_bcd(b20));

   bit sel20 = 1'b0;
   logic [15:0] obs_t, obs_b;
   logic        obs_ds, obs_led;
   logic [2:0]  obs_flags;

   always_comb begin
      if (sel20) begin
         obs_t = t20; obs_b = b20; obs_ds = ds20; obs_led = led20; obs_flags = {rv20, fs20, to20};
      end else begin
         obs_t = t0;  obs_b = b0;  obs_ds = ds0;  obs_led = led0;  obs_flags = {rv0, fs0, to0};
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // flags: {result_valid, false_start, timeout}
   typedef struct {
      logic [2:0] flags;
      int         ms;
   } exp_t;

   exp_t sbq[$];
   int   best_model = 0;
   logic [2:0] prev_flags = 3'b000;

   always @(negedge clk) begin
      exp_t e;
      if (obs_flags != 3'b000 && prev_flags == 3'b000) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected", 32'(obs_flags), 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_flags", 32'(obs_flags), 32'(e.flags));
            chk("sb_time", 32'(obs_t), 32'(bcd(e.ms)));
`ifdef REACTION_BEST_TIME_EN
            if (e.flags == 3'b100 && (best_model == 0 || e.ms < best_model)) best_model = e.ms;
`endif
            chk("sb_best", 32'(obs_b), 32'(bcd(best_model)));
         end
      end
      prev_flags = obs_flags;
   end

   task automatic set_go(input logic v);
      if (sel20) go20 = v; else go0 = v;
   endtask
   task automatic set_react(input logic v);
      if (sel20) react20 = v; else react0 = v;
   endtask
   task automatic set_dd(input logic v);
      if (sel20) dd20 = v; else dd0 = v;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_t0"}, 32'(t0), 32'd0);
      chk({tag, "_b0"}, 32'(b0), 32'd0);
      chk({tag, "_ctl0"}, 32'({ds0, led0, rv0, fs0, to0}), 32'd0);
      chk({tag, "_t20"}, 32'(t20), 32'd0);
      chk({tag, "_b20"}, 32'(b20), 32'd0);
      chk({tag, "_ctl20"}, 32'({ds20, led20, rv20, fs20, to20}), 32'd0);
   endtask

   // Caller is at a negedge; reset takes effect immediately.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      chk_zero(tag);
      @(negedge clk);
      chk_zero({tag, "_hold"});
      rst = 1'b0;
      best_model = 0;
      sbq.delete();
   endtask

   task automatic start_go();
      int k;
      @(negedge clk);
      set_go(1'b1);
      @(negedge clk);
      set_go(1'b0);
      k = 0;
      while (!obs_ds && k < 8) begin
         @(negedge clk);
         k++;
      end
      chk("delay_start_on", 32'(obs_ds), 32'd1);
      chk("wait_time_clr", 32'(obs_t), 32'd0);
      chk("wait_flags_clr", 32'(obs_flags), 32'd0);
   endtask

   task automatic arm(input int dly);
      repeat (dly) @(negedge clk);
      chk("wait_led_off", 32'(obs_led), 32'd0);
      set_dd(1'b1);
      @(negedge clk);
      set_dd(1'b0);
      chk("armed_led", 32'(obs_led), 32'd1);
      chk("armed_ds", 32'(obs_ds), 32'd0);
      chk("armed_t0", 32'(obs_t), 32'd0);
   endtask

   task automatic wait_outcome();
      int k;
      k = 0;
      while (obs_flags == 3'b000 && k < 6) begin
         @(negedge clk);
         k++;
      end
      chk("outcome_seen", 32'(obs_flags != 3'b000), 32'd1);
   endtask

   task automatic count_step(inout int cnt);
      @(negedge clk);
      cnt++;
      if (cnt % 10 == 0 || cnt % 10 == 9) chk("count", 32'(obs_t), 32'(bcd(cnt)));
   endtask

   // react_at < 0: no reaction, expect a timeout at 'limit'.
   task automatic trial(input int dly, input int react_at, input int limit);
      int cnt;
      start_go();
      arm(dly);
      cnt = 0;
      if (react_at >= 0) begin
         sbq.push_back('{3'b100, react_at});
         while (cnt < react_at - 2) count_step(cnt);
         set_react(1'b1);
         count_step(cnt);
         set_react(1'b0);
         count_step(cnt);
         chk("count_at_react", 32'(obs_t), 32'(bcd(cnt)));
         chk("led_before_react", 32'(obs_led), 32'd1);
      end else begin
         sbq.push_back('{3'b001, limit});
         while (cnt < limit) count_step(cnt);
         chk("limit_no_flag", 32'(obs_flags), 32'd0);
         chk("limit_time", 32'(obs_t), 32'(bcd(limit)));
      end
      wait_outcome();
      chk("post_led", 32'(obs_led), 32'd0);
      chk("post_ds", 32'(obs_ds), 32'd0);
   endtask

   task automatic false_start_test();
      start_go();
      repeat (3) @(negedge clk);
      sbq.push_back('{3'b010, 0});
      set_react(1'b1);
      @(negedge clk);
      set_react(1'b0);
      @(negedge clk);
      set_dd(1'b1);
      @(negedge clk);
      set_dd(1'b0);
      wait_outcome();
      chk("fs_flag", 32'(obs_flags), 32'b010);
      chk("fs_ds", 32'(obs_ds), 32'd0);
      chk("fs_time", 32'(obs_t), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("fs_led_off", 32'(obs_led), 32'd0);
      end
   endtask

   task automatic mid_trial_reset();
      int cnt;
      start_go();
      arm(5);
      cnt = 0;
      while (cnt < 42) count_step(cnt);
      chk("pre_reset_time", 32'(obs_t), 32'h0042);
      do_reset("mid_rst");
      repeat (3) @(negedge clk);
      chk("mid_rst_flags", 32'(obs_flags), 32'd0);
      chk("mid_rst_led", 32'(obs_led), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      do_reset("rst");

      trial(1500, 250, 0);
      chk("rv_250", 32'(rv0), 32'd1);
      chk("t_250", 32'(t0), 32'h0250);
      chk("led_250", 32'(led0), 32'd0);

      false_start_test();
      trial(10, 1000, 0);
      chk("t_1000", 32'(t0), 32'h1000);

      trial(10, 300, 0);
      trial(10, 180, 0);
      trial(10, 400, 0);
`ifdef REACTION_BEST_TIME_EN
      chk("best_three", 32'(b0), 32'h0180);
`else
      chk("best_three", 32'(b0), 32'h0000);
`endif

      mid_trial_reset();
      trial(10, 30, 0);

      sel20 = 1'b1;
      do_reset("rst20");
      trial(10, -1, 20);
      chk("to20_flag", 32'({rv20, fs20, to20}), 32'b001);
      chk("to20_time", 32'(t20), 32'h0020);
      trial(10, 20, 20);
      chk("react20_flag", 32'({rv20, fs20, to20}), 32'b100);

      @(negedge clk);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule
